// File: rtl/ddr_mem_dq_responder.sv
// DRAM-side CAS responder: queues decoded RD/WR commands by absolute start
// timestamp, then drives the read preamble/burst or captures write bursts.
module ddr_mem_dq_responder #(
    parameter int DQ_W   = 8,
    parameter int BL     = 8,
    parameter int QDEPTH = 8,
    parameter int COL_W  = 10,
    parameter int TS_W   = 8
) (
    input  logic                CK_t,
    input  logic                reset_n,
    input  logic                cmd_valid,
    input  logic                cmd_is_rd,
    input  logic [COL_W-1:0]    cmd_col,
    input  logic [4:0]          CL,
    input  logic [4:0]          CWL,
    input  logic [4:0]          AL,
    input  logic [1:0]          RD_PRE,
    input  logic [2*DQ_W-1:0]   dq_in,
    input  logic [2*DQ_W-1:0]   mem_rd_data,
    output logic [COL_W-1:0]    mem_rd_addr,
    output logic                mem_wr_en,
    output logic [COL_W-1:0]    mem_wr_addr,
    output logic [2*DQ_W-1:0]   mem_wr_data,
    output logic                dqs_oe,
    output logic                rd_valid,
    output logic [2*DQ_W-1:0]   rd_data,
    output logic                cmd_err
);

    localparam int BEATS = BL / 2;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int QW    = $clog2(QDEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [QW:0]   FULL_CNT  = (QW+1)'(QDEPTH);
    localparam logic [COL_W-1:0] COL_MASK = ~COL_W'(BL - 1);

    typedef enum logic [1:0] {IDLE, PRE, BURST} state_t;

    state_t             r_state, w_state_nxt;
    logic [TS_W-1:0]    r_ts, w_ts_nxt;
    logic [BW-1:0]      r_beat, w_beat_p1;
    logic               r_cur_rd;
    logic [COL_W-1:0]   r_cur_col;

    logic               r_q_rd    [QDEPTH];
    logic [COL_W-1:0]   r_q_col   [QDEPTH];
    logic [TS_W-1:0]    r_q_start [QDEPTH];
    logic [QW-1:0]      r_wp, r_rp;
    logic [QW:0]        r_count;

    logic               r_last_vld, r_last_rd;
    logic [TS_W-1:0]    r_last_start;
    logic               r_err;

    logic               w_head_vld, w_head_rd;
    logic [COL_W-1:0]   w_head_col;
    logic [TS_W-1:0]    w_head_start, w_head_dist;
    logic               w_go_burst, w_go_pre, w_last_beat, w_pop;
    logic [5:0]         w_lat;
    logic [TS_W-1:0]    w_new_start, w_new_diff, w_new_limit;
    logic               w_overlap, w_full, w_accept;

    assign w_ts_nxt     = r_ts + TS_W'(1);
    assign w_beat_p1    = r_beat + BW'(1);
    assign w_last_beat  = (r_beat == LAST_BEAT);
    assign w_head_vld   = (r_count != '0);
    assign w_head_rd    = r_q_rd[r_rp];
    assign w_head_col   = r_q_col[r_rp];
    assign w_head_start = r_q_start[r_rp];

    // Decisions are made one clock ahead so the new state lines up with ts == target.
    assign w_head_dist = w_head_start - w_ts_nxt;
    assign w_go_burst  = w_head_vld && (w_head_dist == '0);
    assign w_go_pre    = w_head_vld && w_head_rd && (w_head_dist != '0)
                         && (w_head_dist <= TS_W'(RD_PRE));

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_go_burst) begin
                    w_state_nxt = BURST;
                    w_pop       = 1'b1;
                end else if (w_go_pre) begin
                    w_state_nxt = PRE;
                end
            end
            PRE: begin
                if (w_go_burst) begin
                    w_state_nxt = BURST;
                    w_pop       = 1'b1;
                end
            end
            BURST: begin
                if (w_last_beat) begin
                    if (w_go_burst) begin
                        w_state_nxt = BURST;
                        w_pop       = 1'b1;
                    end else if (w_go_pre) begin
                        w_state_nxt = PRE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Overlap test is a signed wrap-safe distance from the last accepted start.
    assign w_lat       = cmd_is_rd ? ({1'b0, CL} + {1'b0, AL}) : ({1'b0, CWL} + {1'b0, AL});
    assign w_new_start = r_ts + TS_W'(w_lat);
    assign w_new_diff  = w_new_start - r_last_start;
    assign w_new_limit = TS_W'(BEATS) + ((cmd_is_rd && !r_last_rd) ? TS_W'(RD_PRE) : '0);
    assign w_overlap   = r_last_vld && (w_new_diff[TS_W-1] || (w_new_diff < w_new_limit));
    assign w_full      = (r_count == FULL_CNT) && !w_pop;
    assign w_accept    = cmd_valid && !w_full && !w_overlap;

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ts         <= '0;
            r_beat       <= '0;
            r_cur_rd     <= 1'b0;
            r_cur_col    <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_last_vld   <= 1'b0;
            r_last_rd    <= 1'b0;
            r_last_start <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ts    <= w_ts_nxt;
            r_err   <= cmd_valid && !w_accept;

            if (w_pop) begin
                r_cur_rd  <= w_head_rd;
                r_cur_col <= w_head_col;
                r_beat    <= '0;
                r_rp      <= r_rp + QW'(1);
            end else if (r_state == BURST) begin
                r_beat <= w_beat_p1;
            end

            if (w_accept) begin
                r_wp         <= r_wp + QW'(1);
                r_last_vld   <= 1'b1;
                r_last_rd    <= cmd_is_rd;
                r_last_start <= w_new_start;
            end else if (r_state == IDLE && r_count == '0) begin
                r_last_vld <= 1'b0;
            end

            if (w_accept && !w_pop) begin
                r_count <= r_count + (QW+1)'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - (QW+1)'(1);
            end
        end
    end

    always_ff @(posedge CK_t) begin
        if (w_accept) begin
            r_q_rd[r_wp]    <= cmd_is_rd;
            r_q_col[r_wp]   <= cmd_col & COL_MASK;
            r_q_start[r_wp] <= w_new_start;
        end
    end

    always_comb begin
        rd_valid    = (r_state == BURST) && r_cur_rd;
        dqs_oe      = (r_state == PRE) || rd_valid;
        mem_wr_en   = (r_state == BURST) && !r_cur_rd;
        rd_data     = rd_valid ? mem_rd_data : '0;
        mem_wr_addr = mem_wr_en ? (r_cur_col + (COL_W'(r_beat) << 1)) : '0;
        mem_wr_data = mem_wr_en ? dq_in : '0;
        cmd_err     = r_err;

        // Storage is registered, so each read address leads its beat by one clock.
        mem_rd_addr = '0;
        if (r_state == PRE && w_go_burst) begin
            mem_rd_addr = w_head_col;
        end else if (rd_valid && !w_last_beat) begin
            mem_rd_addr = r_cur_col + (COL_W'(w_beat_p1) << 1);
        end else if (r_state == BURST && w_last_beat && w_go_burst && w_head_rd) begin
            mem_rd_addr = w_head_col;
        end
    end

endmodule

// File: tb/tb_ddr_mem_dq_responder.sv
// Bench for ddr_mem_dq_responder: absolute-time burst model plus directed
// literal checks and randomized command streams.
module tb_ddr_mem_dq_responder;

    localparam int DQ_W     = 8;
    localparam int BL       = 8;
    localparam int QDEPTH   = 8;
    localparam int COL_W    = 10;
    localparam int TS_W     = 8;
    localparam int BEATS    = BL / 2;
    localparam int COL_MASK = (1 << COL_W) - 1;

    logic               CK_t = 1'b0;
    logic               reset_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_is_rd = 1'b0;
    logic [COL_W-1:0]   cmd_col = '0;
    logic [4:0]         CL = '0, CWL = '0, AL = '0;
    logic [1:0]         RD_PRE = 2'd1;
    logic [2*DQ_W-1:0]  dq_in = '0;
    logic [2*DQ_W-1:0]  mem_rd_data = '0;
    logic [COL_W-1:0]   mem_rd_addr, mem_wr_addr;
    logic               mem_wr_en, dqs_oe, rd_valid, cmd_err;
    logic [2*DQ_W-1:0]  mem_wr_data, rd_data;

    ddr_mem_dq_responder #(
        .DQ_W(DQ_W), .BL(BL), .QDEPTH(QDEPTH), .COL_W(COL_W), .TS_W(TS_W)
    ) dut (
        .CK_t(CK_t), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_is_rd(cmd_is_rd),
        .cmd_col(cmd_col), .CL(CL), .CWL(CWL), .AL(AL), .RD_PRE(RD_PRE),
        .dq_in(dq_in), .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .dqs_oe(dqs_oe), .rd_valid(rd_valid), .rd_data(rd_data), .cmd_err(cmd_err)
    );

    always #5 CK_t = ~CK_t;

    int errors = 0;
    int checks = 0;
    int now = 0;

    typedef struct {
        bit rd;
        int col;
        int start;
    } burst_t;
    burst_t acc[$];
    int     errs[$];

    function automatic logic [15:0] memfn(int a);
        return 16'((a * 97 + 13) ^ (a << 6));
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got 0x%0h, expected 0x%0h", name, now, act, exp);
        end
    endtask

    // Storage model: registered read, data is a fixed function of the address.
    always @(posedge CK_t) mem_rd_data <= memfn(int'(mem_rd_addr));

    function automatic void model_cmd();
        int     t;
        int     st;
        int     pend;
        int     lim;
        bit     drop;
        burst_t b;
        t    = now;
        st   = t + (cmd_is_rd ? int'(CL) + int'(AL) : int'(CWL) + int'(AL));
        pend = 0;
        foreach (acc[i]) if (acc[i].start > t + 1) pend++;
        drop = (pend >= QDEPTH);
        if (acc.size() > 0) begin
            b   = acc[acc.size()-1];
            lim = b.start + BEATS + ((cmd_is_rd && !b.rd) ? int'(RD_PRE) : 0);
            if (st < lim) drop = 1'b1;
        end
        if (drop) begin
            errs.push_back(t + 1);
        end else begin
            b.rd    = cmd_is_rd;
            b.col   = int'(cmd_col) & ~(BL - 1);
            b.start = st;
            acc.push_back(b);
        end
    endfunction

    // Absolute, non-wrapping time; the DUT timestamp is this modulo 2^TS_W.
    always @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            now = 0;
            acc.delete();
            errs.delete();
        end else begin
            if (cmd_valid) model_cmd();
            now = now + 1;
        end
    end

    always @(negedge CK_t) begin : cmp
        int e_dqs, e_rv, e_rd, e_ra, e_we, e_wa, e_wd, e_err, s;
        if (reset_n) begin
            e_dqs = 0; e_rv = 0; e_rd = 0; e_ra = 0;
            e_we = 0; e_wa = 0; e_wd = 0; e_err = 0;
            foreach (acc[i]) begin
                s = acc[i].start;
                if (acc[i].rd) begin
                    if (now >= s - int'(RD_PRE) && now < s + BEATS) e_dqs = 1;
                    if (now >= s && now < s + BEATS) begin
                        e_rv = 1;
                        e_rd = int'(memfn((acc[i].col + 2 * (now - s)) & COL_MASK));
                    end
                    if (now >= s - 1 && now < s + BEATS - 1)
                        e_ra = (acc[i].col + 2 * (now + 1 - s)) & COL_MASK;
                end else if (now >= s && now < s + BEATS) begin
                    e_we = 1;
                    e_wa = (acc[i].col + 2 * (now - s)) & COL_MASK;
                    e_wd = int'(dq_in);
                end
            end
            foreach (errs[i]) if (errs[i] == now) e_err = 1;
            chk("dqs_oe",      int'(dqs_oe),      e_dqs);
            chk("rd_valid",    int'(rd_valid),    e_rv);
            chk("rd_data",     int'(rd_data),     e_rd);
            chk("mem_rd_addr", int'(mem_rd_addr), e_ra);
            chk("mem_wr_en",   int'(mem_wr_en),   e_we);
            chk("mem_wr_addr", int'(mem_wr_addr), e_wa);
            chk("mem_wr_data", int'(mem_wr_data), e_wd);
            chk("cmd_err",     int'(cmd_err),     e_err);
        end
    end

    initial begin
        forever begin
            @(posedge CK_t);
            #1 dq_in = 16'($urandom);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CK_t);
        #1;
    endtask

    task automatic goto(int t);
        while (now < t) tick();
    endtask

    task automatic at_neg(int t);
        goto(t);
        @(negedge CK_t);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset_n   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic issue(bit rd, int col, int cl, int cwl, int al);
        cmd_valid = 1'b1;
        cmd_is_rd = rd;
        cmd_col   = COL_W'(col);
        CL        = 5'(cl);
        CWL       = 5'(cwl);
        AL        = 5'(al);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " dqs_oe"},      int'(dqs_oe),      0);
        chk({tag, " rd_valid"},    int'(rd_valid),    0);
        chk({tag, " rd_data"},     int'(rd_data),     0);
        chk({tag, " mem_rd_addr"}, int'(mem_rd_addr), 0);
        chk({tag, " mem_wr_en"},   int'(mem_wr_en),   0);
        chk({tag, " mem_wr_addr"}, int'(mem_wr_addr), 0);
        chk({tag, " mem_wr_data"}, int'(mem_wr_data), 0);
        chk({tag, " cmd_err"},     int'(cmd_err),     0);
    endtask

    initial begin
        int n;
        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Single read, CL=11 AL=0 RD_PRE=1 issued at T=5
        do_reset();
        RD_PRE = 2'd1;
        goto(5);
        issue(1'b1, 'h010, 11, 5, 0);
        at_neg(14); chk("t1 dqs before preamble", int'(dqs_oe), 0);
        at_neg(15); chk("t1 preamble dqs", int'(dqs_oe), 1);
                    chk("t1 preamble rd_valid", int'(rd_valid), 0);
                    chk("t1 first addr", int'(mem_rd_addr), 'h010);
        at_neg(16); chk("t1 beat0 rd_valid", int'(rd_valid), 1);
                    chk("t1 beat0 addr", int'(mem_rd_addr), 'h012);
                    chk("t1 beat0 data", int'(rd_data), int'(memfn('h010)));
        at_neg(18); chk("t1 last addr", int'(mem_rd_addr), 'h016);
        at_neg(19); chk("t1 beat3 rd_valid", int'(rd_valid), 1);
        at_neg(20); chk("t1 after rd_valid", int'(rd_valid), 0);
                    chk("t1 after dqs", int'(dqs_oe), 0);

        // Single write, CWL=9 AL=2 issued at T=3
        do_reset();
        goto(3);
        issue(1'b0, 'h020, 11, 9, 2);
        at_neg(13); chk("t2 before wr_en", int'(mem_wr_en), 0);
        at_neg(14); chk("t2 wr_en", int'(mem_wr_en), 1);
                    chk("t2 addr0", int'(mem_wr_addr), 'h020);
                    chk("t2 data follows dq_in", int'(mem_wr_data), int'(dq_in));
                    chk("t2 no dqs on write", int'(dqs_oe), 0);
        at_neg(17); chk("t2 addr3", int'(mem_wr_addr), 'h026);
        at_neg(18); chk("t2 after wr_en", int'(mem_wr_en), 0);

        // Seamless reads 4 clocks apart with RD_PRE=2
        do_reset();
        RD_PRE = 2'd2;
        goto(5);
        issue(1'b1, 'h100, 11, 5, 0);
        goto(9);
        issue(1'b1, 'h208, 11, 5, 0);
        at_neg(14); chk("t3 preamble start dqs", int'(dqs_oe), 1);
                    chk("t3 early preamble addr", int'(mem_rd_addr), 0);
        at_neg(15); chk("t3 first addr", int'(mem_rd_addr), 'h100);
        n = 0;
        for (int t = 16; t < 24; t++) begin
            at_neg(t);
            if (rd_valid && dqs_oe) n++;
            if (t == 19) chk("t3 seamless next addr", int'(mem_rd_addr), 'h208);
        end
        chk("t3 contiguous beats", n, 8);
        at_neg(24); chk("t3 end rd_valid", int'(rd_valid), 0);

        // Overlapping reads 2 clocks apart
        do_reset();
        RD_PRE = 2'd1;
        goto(5);
        issue(1'b1, 'h040, 11, 5, 0);
        goto(7);
        issue(1'b1, 'h048, 11, 5, 0);
        at_neg(8); chk("t4 cmd_err pulse", int'(cmd_err), 1);
        at_neg(9); chk("t4 cmd_err one clock", int'(cmd_err), 0);
        n = 0;
        for (int t = 10; t < 30; t++) begin
            at_neg(t);
            if (rd_valid) n++;
        end
        chk("t4 rd_valid count", n, 4);

        // Queue full, then the same pattern across the timestamp wrap
        do_reset();
        RD_PRE = 2'd1;
        for (int base_i = 0; base_i < 2; base_i++) begin
            int base;
            base = (base_i == 0) ? 2 : 240;
            for (int k = 0; k < 9; k++) begin
                goto(base + 4 * k);
                issue(1'b1, 'h080 + 8 * k, 31, 5, 20);
            end
            at_neg(base + 33); chk("t5 ninth command dropped", int'(cmd_err), 1);
            n = 0;
            for (int t = base + 34; t < base + 100; t++) begin
                at_neg(t);
                if (rd_valid) n++;
            end
            chk("t5 eight bursts executed", n, 32);
        end

        // Reset during beat 2 of a read
        do_reset();
        RD_PRE = 2'd1;
        goto(5);
        issue(1'b1, 'h0F8, 11, 5, 0);
        at_neg(17); chk("t6 mid burst rd_valid", int'(rd_valid), 1);
        goto(18);
        reset_n = 1'b0;
        #1;
        chk_all_zero("t6 async reset");
        tick();
        tick();
        reset_n = 1'b1;
        n = 0;
        for (int t = 0; t < 40; t++) begin
            at_neg(t);
            if (rd_valid || dqs_oe) n++;
        end
        chk("t6 nothing resumes", n, 0);

        // Randomized command streams
        for (int r = 0; r < 3; r++) begin
            do_reset();
            RD_PRE = 2'($urandom_range(1, 2));
            repeat (300) begin
                if ($urandom_range(0, 2) == 0) begin
                    cmd_valid = 1'b1;
                    cmd_is_rd = 1'($urandom_range(0, 1));
                    cmd_col   = COL_W'($urandom);
                    CL        = 5'($urandom_range(5, 20));
                    CWL       = 5'($urandom_range(5, 20));
                    AL        = 5'($urandom_range(0, 10));
                end else begin
                    cmd_valid = 1'b0;
                end
                tick();
            end
            cmd_valid = 1'b0;
            repeat (80) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
